control_sequencer: RTL
======================

// Module: control_sequencer
// PURPOSE
//  Unified, parametrised micro-sequencer. Supersedes the separate fetch, decode,
//  move, movi, ALU, ALUI, load and store FSMs of the single-bus CPU.
//  Drives every bus-source/sink enable. Scales register count and data width.
//  Adds run/halt control, one-hot checks on register indices, and an MFC timeout fault.
// PARAMETERS
//  DATA_W       16  bus/instruction width; op field = [DATA_W-1 -: 4]
//  FIELD_W       6  width of the Ri field and of the Rj field; Rj = [FIELD_W-1:0]
//  NUM_REGS      5  bus registers R0..R(n-2); index NUM_REGS-1 is output port P0
//  MFC_TIMEOUT  15  max cycles spent waiting for mfc before fault (>=1)
// PORTS
//  clk            in   1         rising-edge clock
//  reset          in   1         synchronous, active-high
//  run            in   1         1 = keep fetching; sampled only in IDLE/DONE
//  ir_q           in   DATA_W    IR contents (op, Ri, Rj)
//  mfc            in   1         memory function complete
//  reg_rd_en      out  NUM_REGS  one-hot: register drives bus
//  reg_wr_en      out  NUM_REGS  one-hot: register loads bus
//  pc_read / pc_inc             out 1  PC drives bus / PC += 1
//  mar_write / mar_mem_read     out 1  MAR loads bus / MAR drives memory address
//  mem_en / mem_rw              out 1  memory enable / 1 = read, 0 = write
//  mdr_mem_write / mdr_read     out 1  MDR loads memory data / MDR drives bus
//  mdr_write / mdr_mem_read     out 1  MDR loads bus / MDR drives memory data
//  ir_write                     out 1  IR loads bus
//  alu_in1_wr / alu_in2_wr / alu_out_en  out 1  ALU operand latches / result drive
//  alu_op         out  3         ALU opControl
//  imm_en         out  1         imm_out drives bus
//  imm_out        out  DATA_W    zero-extended Rj field
//  instr_done     out  1         1-cycle pulse when an instruction retires
//  fault          out  1         sticky; cleared by reset only
// BEHAVIOUR
//  - Outputs are Moore (decoded from state) and 0 in IDLE.
//  - Reset: state=IDLE, timeout counter=0, fault=0. Reset wins over every other
//    event, including a reset during a memory wait.
//  - Exactly one bus driver per cycle: reg_rd_en | pc_read | mdr_read | alu_out_en | imm_en.
//  - IDLE -> FA when run=1. DONE pulses instr_done, then goes -> FA if run=1, else -> IDLE.
//  - Fetch: FA (pc_read, mar_write) -> FW (mar_mem_read, mem_en, mem_rw=1; wait for mfc)
//    -> FL (mdr_mem_write) -> FI (mdr_read, ir_write, pc_inc) -> DEC.
//  - DEC: Ri or Rj >= NUM_REGS -> FAULT. Otherwise dispatch on op:
//    0000 MOV  : MV (rd Rj, wr Ri) -> DONE
//    0001 MOVI : MI (imm_en, wr Ri) -> DONE
//    0010 LOAD : MA (rd Rj, mar_write) -> MW rd -> LL (mdr_mem_write)
//                -> LR (mdr_read, wr Ri) -> DONE
//    0011 STORE: MA -> SD (rd Ri, mdr_write) -> MW wr (mem_rw=0, mdr_mem_read) -> DONE
//    01xx ALUI : A1 (rd Ri, alu_in1_wr) -> A2 (imm_en, alu_in2_wr)
//                -> A3 (alu_out_en, wr Ri) -> DONE; alu_op={1'b0,op[1:0]}
//    1xxx ALU  : same as ALUI, except A2 uses rd Rj in place of imm_en; alu_op=op[2:0]
//  - alu_op is held from DEC to DONE.
//  - Wait states (FW, MW): counter clears on entry and increments each cycle mfc=0.
//    mfc=1 advances on the next edge, also when it arrives in the entry cycle.
//    Counter == MFC_TIMEOUT with mfc=0 -> FAULT. In that last cycle, mfc=1 takes
//    priority over the timeout.
//  - FAULT: all enables 0, fault=1, remains until reset.
//  - run deasserted mid-instruction: the instruction completes, then the block idles.
//  - PC wraps naturally in the PC block; the sequencer does no address arithmetic.
// STRUCTURE
//  - Shared package cpu_pkg: state enum, opcode constants (OP_MOV, OP_MOVI, OP_LOAD,
//    OP_STORE, OP_ALUI_MASK, OP_ALU_MASK), field-slice localparams.
//  - One sub-module, mfc_wait_timer: counter, clear, expired flag;
//    parameter MFC_TIMEOUT.
//  - Index -> one-hot decode is a function in cpu_pkg.
// TESTING
//  - reset, run=1, mfc set 2 cycles after mem_en; IR=0x0042 (MOV R1<-R2)
//    -> reg_rd_en=00100, reg_wr_en=00010 in the same cycle; instr_done 1 cycle later.
//  - IR=0x10C5 (MOVI R3<-5) -> imm_out=0x0005, imm_en=1, reg_wr_en=01000.
//  - IR=0x9081 (ALU op1 R2,R1) -> sequence A1/A2/A3, alu_op=001,
//    A3: alu_out_en=1 with reg_wr_en=00100.
//  - IR=0x2043 (LOAD R1<-[R3]) with mfc after 3 cycles -> mem_rw=1 throughout MW;
//    LR: mdr_read=1 with reg_wr_en=00010.
//  - STORE with mfc never asserted -> fault=1 after exactly MFC_TIMEOUT wait cycles,
//    all enables 0; reset clears fault.
//  - IR=0x0047 (Rj=7 >= NUM_REGS) -> FAULT from DEC. Separately, run dropped
//    mid-instruction -> one instr_done pulse, then IDLE with all outputs 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and helpers for the single-bus CPU control sequencer:
// state encoding, opcode constants, instruction field widths and decode functions.
package cpu_pkg;

    localparam int OP_W     = 4;
    // Register indices are decoded through a fixed-size one-hot; FIELD_W must not exceed IDX_W
    localparam int IDX_W    = 6;
    localparam int MAX_REGS = 64;

    localparam logic [OP_W-1:0] OP_MOV       = 4'b0000;
    localparam logic [OP_W-1:0] OP_MOVI      = 4'b0001;
    localparam logic [OP_W-1:0] OP_LOAD      = 4'b0010;
    localparam logic [OP_W-1:0] OP_STORE     = 4'b0011;
    localparam logic [OP_W-1:0] OP_ALUI_MASK = 4'b1100;
    localparam logic [OP_W-1:0] OP_ALUI_VAL  = 4'b0100;
    localparam logic [OP_W-1:0] OP_ALU_MASK  = 4'b1000;
    localparam logic [OP_W-1:0] OP_ALU_VAL   = 4'b1000;

    typedef enum logic [4:0] {
        S_IDLE  = 5'd0,  S_FA = 5'd1,  S_FW = 5'd2,  S_FL = 5'd3,  S_FI = 5'd4,
        S_DEC   = 5'd5,  S_MV = 5'd6,  S_MI = 5'd7,  S_MA = 5'd8,  S_MW = 5'd9,
        S_LL    = 5'd10, S_LR = 5'd11, S_SD = 5'd12, S_A1 = 5'd13, S_A2 = 5'd14,
        S_A3    = 5'd15, S_DONE = 5'd16, S_FAULT = 5'd17
    } state_e;

    function automatic logic [MAX_REGS-1:0] reg_onehot(input logic [IDX_W-1:0] idx);
        logic [MAX_REGS-1:0] m;
        m      = {MAX_REGS{1'b0}};
        m[idx] = 1'b1;
        return m;
    endfunction

    // Non-ALU opcodes carry no ALU operation and report 000
    function automatic logic [2:0] alu_op_of(input logic [OP_W-1:0] op);
        logic [2:0] r;
        if ((op & OP_ALU_MASK) == OP_ALU_VAL) begin
            r = op[2:0];
        end else if ((op & OP_ALUI_MASK) == OP_ALUI_VAL) begin
            r = {1'b0, op[1:0]};
        end else begin
            r = 3'b000;
        end
        return r;
    endfunction

endpackage

// File: rtl/mfc_wait_timer.sv
// Counts cycles spent waiting for memory-function-complete; flags expiry once
// the count reaches MFC_TIMEOUT.
module mfc_wait_timer #(
    parameter int MFC_TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic tick,
    output logic expired
);
    localparam int CNT_W = $clog2(MFC_TIMEOUT + 1);

    logic [CNT_W-1:0] count_r;

    assign expired = (count_r == CNT_W'(MFC_TIMEOUT));

    // Wait counter: held at zero outside wait states, saturates at the limit
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            count_r <= {CNT_W{1'b0}};
        end else if (tick && !expired) begin
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// Unified micro-sequencer for the single-bus CPU: fetch, decode and execute of
// MOV/MOVI/LOAD/STORE/ALU/ALUI with run/halt, index checks and an MFC timeout fault.
module control_sequencer
    import cpu_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int FIELD_W     = 6,
    parameter int NUM_REGS    = 5,
    parameter int MFC_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    input  logic [DATA_W-1:0]   ir_q,
    input  logic                mfc,
    output logic [NUM_REGS-1:0] reg_rd_en,
    output logic [NUM_REGS-1:0] reg_wr_en,
    output logic                pc_read,
    output logic                pc_inc,
    output logic                mar_write,
    output logic                mar_mem_read,
    output logic                mem_en,
    output logic                mem_rw,
    output logic                mdr_mem_write,
    output logic                mdr_read,
    output logic                mdr_write,
    output logic                mdr_mem_read,
    output logic                ir_write,
    output logic                alu_in1_wr,
    output logic                alu_in2_wr,
    output logic                alu_out_en,
    output logic [2:0]          alu_op,
    output logic                imm_en,
    output logic [DATA_W-1:0]   imm_out,
    output logic                instr_done,
    output logic                fault
);
    state_e state_r, state_next_s;

    logic [OP_W-1:0]     op_s;
    logic [FIELD_W-1:0]  ri_s, rj_s;
    logic [MAX_REGS-1:0] ri_mask_s, rj_mask_s;
    logic                ri_ok_s, rj_ok_s, is_alui_s, is_store_s, rj_is_reg_s, dec_ok_s;
    logic [2:0]          alu_op_s;
    logic                waiting_s, expired_s;

    assign op_s = ir_q[DATA_W-1 -: OP_W];
    assign ri_s = ir_q[2*FIELD_W-1:FIELD_W];
    assign rj_s = ir_q[FIELD_W-1:0];

    // An index is legal only when its one-hot lands inside the implemented registers
    assign ri_mask_s = reg_onehot(IDX_W'(ri_s));
    assign rj_mask_s = reg_onehot(IDX_W'(rj_s));
    assign ri_ok_s   = (|ri_mask_s[NUM_REGS-1:0]) & ~(|ri_mask_s[MAX_REGS-1:NUM_REGS]);
    assign rj_ok_s   = (|rj_mask_s[NUM_REGS-1:0]) & ~(|rj_mask_s[MAX_REGS-1:NUM_REGS]);

    // Rj is an immediate, not a register, for MOVI and ALUI
    assign is_alui_s   = ((op_s & OP_ALUI_MASK) == OP_ALUI_VAL);
    assign is_store_s  = (op_s == OP_STORE);
    assign rj_is_reg_s = (op_s != OP_MOVI) && !is_alui_s;
    assign dec_ok_s    = ri_ok_s && (rj_ok_s || !rj_is_reg_s);
    assign alu_op_s    = alu_op_of(op_s);

    assign waiting_s = (state_r == S_FW) || (state_r == S_MW);

    mfc_wait_timer #(
        .MFC_TIMEOUT(MFC_TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (!waiting_s),
        .tick   (waiting_s && !mfc),
        .expired(expired_s)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and Moore output decode
    always_comb begin
        state_next_s  = state_r;
        reg_rd_en     = {NUM_REGS{1'b0}};
        reg_wr_en     = {NUM_REGS{1'b0}};
        pc_read       = 1'b0;
        pc_inc        = 1'b0;
        mar_write     = 1'b0;
        mar_mem_read  = 1'b0;
        mem_en        = 1'b0;
        mem_rw        = 1'b0;
        mdr_mem_write = 1'b0;
        mdr_read      = 1'b0;
        mdr_write     = 1'b0;
        mdr_mem_read  = 1'b0;
        ir_write      = 1'b0;
        alu_in1_wr    = 1'b0;
        alu_in2_wr    = 1'b0;
        alu_out_en    = 1'b0;
        alu_op        = 3'b000;
        imm_en        = 1'b0;
        imm_out       = {DATA_W{1'b0}};
        instr_done    = 1'b0;
        fault         = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (run) state_next_s = S_FA;
                else     state_next_s = S_IDLE;
            end
            S_FA: begin
                pc_read      = 1'b1;
                mar_write    = 1'b1;
                state_next_s = S_FW;
            end
            // mfc wins over expiry in the final wait cycle
            S_FW: begin
                mar_mem_read = 1'b1;
                mem_en       = 1'b1;
                mem_rw       = 1'b1;
                if (mfc)            state_next_s = S_FL;
                else if (expired_s) state_next_s = S_FAULT;
                else                state_next_s = S_FW;
            end
            S_FL: begin
                mdr_mem_write = 1'b1;
                state_next_s  = S_FI;
            end
            S_FI: begin
                mdr_read     = 1'b1;
                ir_write     = 1'b1;
                pc_inc       = 1'b1;
                state_next_s = S_DEC;
            end
            S_DEC: begin
                if (!dec_ok_s)                                 state_next_s = S_FAULT;
                else if (op_s == OP_MOV)                       state_next_s = S_MV;
                else if (op_s == OP_MOVI)                      state_next_s = S_MI;
                else if (op_s == OP_LOAD || op_s == OP_STORE)  state_next_s = S_MA;
                else                                           state_next_s = S_A1;
            end
            S_MV: begin
                reg_rd_en    = rj_mask_s[NUM_REGS-1:0];
                reg_wr_en    = ri_mask_s[NUM_REGS-1:0];
                state_next_s = S_DONE;
            end
            S_MI: begin
                imm_en       = 1'b1;
                imm_out      = DATA_W'(rj_s);
                reg_wr_en    = ri_mask_s[NUM_REGS-1:0];
                state_next_s = S_DONE;
            end
            S_MA: begin
                reg_rd_en = rj_mask_s[NUM_REGS-1:0];
                mar_write = 1'b1;
                if (is_store_s) state_next_s = S_SD;
                else            state_next_s = S_MW;
            end
            S_SD: begin
                reg_rd_en    = ri_mask_s[NUM_REGS-1:0];
                mdr_write    = 1'b1;
                state_next_s = S_MW;
            end
            S_MW: begin
                mar_mem_read = 1'b1;
                mem_en       = 1'b1;
                mem_rw       = !is_store_s;
                mdr_mem_read = is_store_s;
                if (mfc)            state_next_s = is_store_s ? S_DONE : S_LL;
                else if (expired_s) state_next_s = S_FAULT;
                else                state_next_s = S_MW;
            end
            S_LL: begin
                mdr_mem_write = 1'b1;
                state_next_s  = S_LR;
            end
            S_LR: begin
                mdr_read     = 1'b1;
                reg_wr_en    = ri_mask_s[NUM_REGS-1:0];
                state_next_s = S_DONE;
            end
            S_A1: begin
                reg_rd_en    = ri_mask_s[NUM_REGS-1:0];
                alu_in1_wr   = 1'b1;
                state_next_s = S_A2;
            end
            S_A2: begin
                alu_in2_wr = 1'b1;
                if (is_alui_s) begin
                    imm_en  = 1'b1;
                    imm_out = DATA_W'(rj_s);
                end else begin
                    reg_rd_en = rj_mask_s[NUM_REGS-1:0];
                end
                state_next_s = S_A3;
            end
            S_A3: begin
                alu_out_en   = 1'b1;
                reg_wr_en    = ri_mask_s[NUM_REGS-1:0];
                state_next_s = S_DONE;
            end
            S_DONE: begin
                instr_done = 1'b1;
                if (run) state_next_s = S_FA;
                else     state_next_s = S_IDLE;
            end
            S_FAULT: begin
                fault        = 1'b1;
                state_next_s = S_FAULT;
            end
            default: begin
                state_next_s = S_FAULT;
            end
        endcase
        if (state_r inside {S_DEC, S_MV, S_MI, S_MA, S_SD, S_MW, S_LL, S_LR,
                            S_A1, S_A2, S_A3, S_DONE}) begin
            alu_op = alu_op_s;
        end else begin
            alu_op = 3'b000;
        end
    end

endmodule
